// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
// Package : rv32_pkg
// Purpose : Shared RV32 front-end constants: reset PC, canonical nop,
//           base opcodes and the fetch FSM state encoding.
// Revision: 1.0 - initial release
// ============================================================================
package rv32_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

  // Base opcodes seen on instr[6:0]
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [1:0] {
    FS_RESET_WAIT = 2'd0,
    FS_RUN        = 2'd1,
    FS_DRAIN      = 2'd2
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/instr_fifo.sv
`default_nettype none
// ============================================================================
// Module  : instr_fifo
// Purpose : Small synchronous FIFO holding fetched {instr, pc} entries.
//           Power-of-two depth, flush clears occupancy in one edge, and a
//           push is accepted while full when a pop happens in the same cycle.
// Revision: 1.0 - initial release
// ============================================================================
module instr_fifo #(
  parameter int               DEPTH     = 2,
  parameter int               WIDTH     = 64,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;

  // Storage, pointers and occupancy; reset preloads every slot so the head is defined
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= RESET_VAL;
      end
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : fetch_unit
// Purpose : RV32 instruction fetch. Issues word fetches, tracks responses in
//           order, buffers {instr, pc} for decode and squashes in-flight
//           responses after a redirect from execute.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = rv32_pkg::RESET_PC,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc4,
  input  logic        decode_ready
);

  import rv32_pkg::*;

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_e  state_q;
  logic [31:0]   fetch_pc_q;
  logic [31:0]   resp_pc_q;
  logic [2:0]    outstanding_q;
  logic [2:0]    outstanding_d;
  logic [2:0]    drop_cnt_q;
  logic [31:0]   redirect_tgt;
  logic [3:0]    occupancy;
  logic          accept;
  logic          rsp;
  logic          rsp_drop;
  logic          pop;
  logic          push;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [63:0]   fifo_head;
  logic          unused_pc_bits;

  // Low target bits are discarded: fetches are always word aligned
  assign redirect_tgt   = {redirect_pc[31:2], 2'b00};
  assign unused_pc_bits = ^redirect_pc[1:0];

  // Requests are throttled so every accepted fetch is guaranteed a buffer slot
  assign occupancy = {1'b0, outstanding_q} + 4'(fifo_count);
  assign imem_req  = (state_q == FS_RUN) && (occupancy < 4'(BUF_DEPTH)) && !redirect;
  assign imem_addr = fetch_pc_q;
  assign accept    = imem_req && imem_ready;

  // A response with nothing outstanding is a protocol error and is ignored
  assign rsp      = imem_rvalid && (outstanding_q != 3'd0);
  assign rsp_drop = rsp && (drop_cnt_q != 3'd0);
  assign pop      = !fifo_empty && decode_ready && !redirect;
  assign push     = rsp && !rsp_drop && !redirect && (!fifo_full || pop);

  assign outstanding_d = outstanding_q + 3'(accept) - 3'(rsp);

  assign instr_valid = !fifo_empty;
  assign instr       = fifo_head[63:32];
  assign instr_pc    = fifo_head[31:0];
  assign instr_pc4   = fifo_head[31:0] + 32'd4;

  instr_fifo #(
    .DEPTH     (BUF_DEPTH),
    .WIDTH     (64),
    .RESET_VAL ({NOP_INSTR, RESET_PC})
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (push),
    .push_data ({imem_rdata, resp_pc_q}),
    .pop       (pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Fetch FSM with fetch/response PCs and in-flight bookkeeping; redirect wins everything
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= FS_RESET_WAIT;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= 3'd0;
      drop_cnt_q    <= 3'd0;
    end else begin
      outstanding_q <= outstanding_d;
      if (redirect) begin
        // Everything still in flight after this edge belongs to the old path
        fetch_pc_q <= redirect_tgt;
        resp_pc_q  <= redirect_tgt;
        drop_cnt_q <= outstanding_d;
        state_q    <= (outstanding_d != 3'd0) ? FS_DRAIN : FS_RUN;
      end else begin
        if (accept) begin
          fetch_pc_q <= fetch_pc_q + 32'd4;
        end
        if (push) begin
          resp_pc_q <= resp_pc_q + 32'd4;
        end
        if (rsp_drop) begin
          drop_cnt_q <= drop_cnt_q - 3'd1;
        end
        case (state_q)
          FS_RESET_WAIT: state_q <= FS_RUN;
          FS_RUN:        state_q <= FS_RUN;
          FS_DRAIN: begin
            if ((drop_cnt_q == 3'd0) || (rsp_drop && (drop_cnt_q == 3'd1))) begin
              state_q <= FS_RUN;
            end
          end
          default:       state_q <= FS_RESET_WAIT;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
